// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable Mealy serial sequence detector
// Length, pattern and overlap mode are loaded at runtime; z fires on the final pattern bit.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               x,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat,
  output logic               cfg_err
);

  typedef enum logic {S_FILL, S_ARMED} state_t;

  localparam logic [MAX_LEN-1:0] PAT_LSB = {{(MAX_LEN-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]   LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] pat, hist, hist_nxt, mask, cand;
  logic [LEN_W-1:0]   len, fill, fill_nxt;
  logic               ovl, accept, len_ok, load_ok, hit;

  assign accept  = in_valid & en & ~cfg_load & ~reset;
  assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_MAX);
  assign load_ok = cfg_load & len_ok;

  // Only the low len bits of the candidate window take part in the compare.
  assign mask = (PAT_LSB << len) - PAT_LSB;
  assign cand = {hist[MAX_LEN-2:0], x};
  assign hit  = ((cand ^ pat) & mask) == '0;

  assign cnt_sat = &match_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FILL;
      hist        <= '0;
      fill        <= '0;
      pat         <= MAX_LEN'(5);
      len         <= LEN_W'(3);
      ovl         <= 1'b1;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      cfg_err <= cfg_load & ~len_ok;
      if (load_ok) begin
        pat         <= cfg_pattern;
        len         <= cfg_len;
        ovl         <= cfg_overlap;
        match_count <= '0;
      end else if (z && !cnt_sat) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    if (load_ok) begin
      hist_nxt  = '0;
      fill_nxt  = '0;
      // A single-bit pattern has nothing to fill, so it arms immediately.
      state_nxt = (cfg_len == LEN_ONE) ? S_ARMED : S_FILL;
    end else if (accept) begin
      hist_nxt = cand;
      if (state == S_FILL) begin
        fill_nxt = fill + LEN_ONE;
        if (fill + LEN_ONE == len - LEN_ONE) begin
          state_nxt = S_ARMED;
        end
      end else if (hit && !ovl && (len != LEN_ONE)) begin
        fill_nxt  = '0;
        state_nxt = S_FILL;
      end
    end
  end

  always_comb begin
    z = 1'b0;
    if (state == S_ARMED && accept && hit) begin
      z = 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - bench for seq_detector_param
// Two instances (8-bit and 3-bit counters) share stimulus; a queue-based model predicts outputs.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic       x = 1'b0;
  logic       z, z_s, cnt_sat, cnt_sat_s, cfg_err, cfg_err_s;
  logic [7:0] match_count;
  logic [2:0] match_count_s;

  int nasrt = 0;
  int nfail = 0;

  int m_len, m_pat, m_cnt;
  bit m_ovl, m_err;
  int mq[$];

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .x(x), .z(z), .match_count(match_count),
    .cnt_sat(cnt_sat), .cfg_err(cfg_err)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .x(x), .z(z_s), .match_count(match_count_s),
    .cnt_sat(cnt_sat_s), .cfg_err(cfg_err_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nasrt++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, check Mealy z before the edge, registered outputs after.
  task automatic step(input bit r, input bit e, input bit v, input bit xx, input bit ld);
    bit acc, ez, legal;
    int tmp[$];
    int val;
    @(negedge clk);
    reset = r; en = e; in_valid = v; x = xx; cfg_load = ld;
    acc = !r && e && v && !ld;
    ez = 1'b0;
    tmp = mq;
    if (acc) begin
      tmp.push_back(int'(xx));
      if (tmp.size() >= m_len) begin
        val = 0;
        for (int i = tmp.size() - m_len; i < tmp.size(); i++) val = val * 2 + tmp[i];
        ez = (val == (m_pat % (1 << m_len)));
      end
    end
    #1;
    chk("z", z, ez);
    chk("z_s", z_s, ez);
    @(posedge clk);
    #1;
    if (r) begin
      m_len = 3; m_pat = 5; m_ovl = 1'b1; m_cnt = 0; m_err = 1'b0;
      mq.delete();
    end else if (ld) begin
      legal = (cfg_len >= 1) && (cfg_len <= 8);
      m_err = !legal;
      if (legal) begin
        m_len = int'(cfg_len); m_pat = int'(cfg_pattern); m_ovl = cfg_overlap; m_cnt = 0;
        mq.delete();
      end
    end else begin
      m_err = 1'b0;
      if (acc) begin
        mq = tmp;
        while (mq.size() > m_len) void'(mq.pop_front());
        if (ez) begin
          m_cnt++;
          if (!m_ovl) mq.delete();
        end
      end
    end
    chk("match_count", match_count, (m_cnt > 255) ? 255 : m_cnt);
    chk("match_count_s", match_count_s, (m_cnt > 7) ? 7 : m_cnt);
    chk("cnt_sat", cnt_sat, m_cnt >= 255);
    chk("cnt_sat_s", cnt_sat_s, m_cnt >= 7);
    chk("cfg_err", cfg_err, m_err);
    chk("cfg_err_s", cfg_err_s, m_err);
  endtask

  task automatic feed(input bit b);
    step(1'b0, 1'b1, 1'b1, b, 1'b0);
  endtask

  task automatic load(input int l, input int p, input bit o);
    cfg_len = 4'(l); cfg_pattern = 8'(p); cfg_overlap = o;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    bit r, ld, e, v, b;

    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_count", match_count, 0);

    feed(1); feed(0); feed(1); feed(0); feed(1);
    chk("default_overlap_cnt", match_count, 2);

    load(4, 4'b1101, 1'b0);
    feed(1); feed(1); feed(0); feed(1); feed(1); feed(0); feed(1);
    chk("nonoverlap_cnt", match_count, 1);
    load(4, 4'b1101, 1'b1);
    feed(1); feed(1); feed(0); feed(1); feed(1); feed(0); feed(1);
    chk("overlap_cnt", match_count, 2);

    load(3, 3'b101, 1'b1);
    feed(1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'(i), 1'b0);
    feed(0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'(i + 1), 1'b0);
    feed(1);
    chk("gap_cnt", match_count, 1);

    load(0, 8'hff, 1'b0);
    chk("illegal0_err", cfg_err, 1);
    feed(0);
    chk("illegal0_err_drop", cfg_err, 0);
    load(9, 8'hff, 1'b0);
    chk("illegal9_err", cfg_err, 1);
    feed(1);
    chk("after_illegal_cnt", match_count, 2);

    load(1, 1, 1'b0);
    for (int i = 0; i < 10; i++) feed(1);
    chk("sat_cnt_s", match_count_s, 7);
    chk("sat_flag_s", cnt_sat_s, 1);
    chk("sat_cnt_wide", match_count, 10);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    feed(1); feed(0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    feed(1);
    chk("reset_mid_z", match_count, 0);
    feed(0); feed(1);
    chk("reset_mid_cnt", match_count, 1);

    en = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 29) == 0);
      if (ld) begin
        cfg_len = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 1) == 0) cfg_len = 4'($urandom_range(1, 3));
        cfg_pattern = 8'($urandom);
        cfg_overlap = 1'($urandom);
      end
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 4) != 0);
      b = 1'($urandom);
      step(r, e, v, b, ld);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
